// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control sequencer: state and
// instruction-class encodings, opcodes, ALU function selects, PC-select codes
// and the control-word layout.
package legv8_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_MEM   = 2'b10,
      ST_HALT  = 2'b11
   } state_e;

   typedef enum logic [2:0] {
      CL_ILLEGAL = 3'd0,
      CL_ADD     = 3'd1,
      CL_SUB     = 3'd2,
      CL_ADDI    = 3'd3,
      CL_LDUR    = 3'd4,
      CL_STUR    = 3'd5,
      CL_B       = 3'd6,
      CL_CBZ     = 3'd7
   } iclass_e;

   // Opcodes, left-aligned at IR[31]; each has its own width.
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   // ALU function selects; values follow the ALU's own encoding.
   localparam logic [4:0] FS_ADD   = 5'b01000;
   localparam logic [4:0] FS_SUB   = 5'b01001;
   localparam logic [4:0] FS_PASSB = 5'b00111;

   // PC-select codes.
   localparam logic [1:0] PSEL_HOLD   = 2'b00;
   localparam logic [1:0] PSEL_INC    = 2'b01;
   localparam logic [1:0] PSEL_BRANCH = 2'b11;

   localparam logic [4:0] REG_XZR = 5'd31;

   // Control word, MSB first: field order fixes the bit positions.
   typedef struct packed {
      logic [1:0] psel;    // [30:29]
      logic [4:0] da;      // [28:24]
      logic [4:0] sa;      // [23:19]
      logic [4:0] sb;      // [18:14]
      logic [4:0] fsel;    // [13:9]
      logic       regw;    // [8]
      logic       ramw;    // [7]
      logic       en_mem;  // [6]
      logic       en_alu;  // [5]
      logic       en_b;    // [4]
      logic       en_pc;   // [3]
      logic       bsel;    // [2]
      logic       pcsel;   // [1]
      logic       sl;      // [0]
   } ctrl_t;

   localparam ctrl_t CW_ZERO  = ctrl_t'(31'd0);
   localparam ctrl_t CW_IDLE  = ctrl_t'({PSEL_HOLD, REG_XZR, REG_XZR, REG_XZR,
                                         5'd0, 9'd0});
   localparam ctrl_t CW_FETCH = ctrl_t'({PSEL_HOLD, REG_XZR, REG_XZR, REG_XZR,
                                         5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                         1'b1, 1'b0, 1'b0, 1'b0});

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// extracts register fields and the class-specific constant K.
module instr_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output iclass_e     class_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rn_o,
   output logic [4:0]  rm_o,
   output logic [63:0] k_o
);

   assign rd_o = ir_i[4:0];
   assign rn_o = ir_i[9:5];
   assign rm_o = ir_i[20:16];

   // Opcode match (variable-width opcodes) and constant extraction.
   always_comb begin
      class_o = CL_ILLEGAL;
      k_o     = '0;
      if (ir_i[31:26] == OP_B) begin
         class_o = CL_B;
         k_o     = {{38{ir_i[25]}}, ir_i[25:0]};
      end else if (ir_i[31:24] == OP_CBZ) begin
         class_o = CL_CBZ;
         k_o     = {{45{ir_i[23]}}, ir_i[23:5]};
      end else if (ir_i[31:22] == OP_ADDI) begin
         class_o = CL_ADDI;
         k_o     = {52'd0, ir_i[21:10]};
      end else if (ir_i[31:21] == OP_ADD) begin
         class_o = CL_ADD;
      end else if (ir_i[31:21] == OP_SUB) begin
         class_o = CL_SUB;
      end else if (ir_i[31:21] == OP_LDUR) begin
         class_o = CL_LDUR;
         k_o     = {{55{ir_i[20]}}, ir_i[20:12]};
      end else if (ir_i[31:21] == OP_STUR) begin
         class_o = CL_STUR;
         k_o     = {{55{ir_i[20]}}, ir_i[20:12]};
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetches into IR, then steps through
// EXEC and (for loads/stores) MEM, driving the datapath control word and K.
module instr_sequencer
   import legv8_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] mem_data,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic [30:0] controlword,
   output logic [63:0] K,
   output logic [1:0]  state,
   output logic        halted
);

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   ctrl_t       cw;

   iclass_e     dec_class;
   logic [4:0]  dec_rd, dec_rn, dec_rm;
   logic [63:0] dec_k;

   instr_decode u_decode (
      .ir_i    (ir_q),
      .class_o (dec_class),
      .rd_o    (dec_rd),
      .rn_o    (dec_rn),
      .rm_o    (dec_rm),
      .k_o     (dec_k)
   );

   // State and instruction register; reset aborts any instruction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state, control-word and K generation.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cw      = CW_IDLE;
      K       = '0;
      case (state_q)
         ST_FETCH: begin
            cw = CW_FETCH;
            if (mem_ready) begin
               ir_d    = mem_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            K       = dec_k;
            state_d = ST_FETCH;
            case (dec_class)
               CL_ADD, CL_SUB, CL_ADDI: begin
                  cw.sa     = dec_rn;
                  cw.sb     = dec_rm;
                  cw.da     = dec_rd;
                  cw.fsel   = (dec_class == CL_SUB) ? FS_SUB : FS_ADD;
                  cw.en_alu = 1'b1;
                  cw.regw   = 1'b1;
                  cw.sl     = ir_q[29];
                  cw.psel   = PSEL_INC;
                  cw.bsel   = (dec_class == CL_ADDI);
               end
               CL_LDUR, CL_STUR: begin
                  cw.sa     = dec_rn;
                  cw.bsel   = 1'b1;
                  cw.fsel   = FS_ADD;
                  cw.en_alu = 1'b1;
                  state_d   = ST_MEM;
               end
               CL_B: begin
                  cw.psel  = PSEL_BRANCH;
                  cw.pcsel = 1'b1;
               end
               CL_CBZ: begin
                  cw.sb     = dec_rd;
                  cw.fsel   = FS_PASSB;
                  cw.en_alu = 1'b1;
                  if (alu_zero) begin
                     cw.psel  = PSEL_BRANCH;
                     cw.pcsel = 1'b1;
                  end else begin
                     cw.psel = PSEL_INC;
                  end
               end
               default: begin
                  cw      = CW_ZERO;
                  K       = '0;
                  state_d = ST_HALT;
               end
            endcase
         end
         ST_MEM: begin
            // Address terms stay on the ALU for the whole access; the write
            // strobe and PC step are held back until the bus completes.
            K         = dec_k;
            cw.sa     = dec_rn;
            cw.bsel   = 1'b1;
            cw.fsel   = FS_ADD;
            cw.en_alu = 1'b1;
            cw.en_mem = 1'b1;
            if (dec_class == CL_LDUR) begin
               cw.da = dec_rd;
            end else begin
               cw.sb = dec_rd;
            end
            if (mem_ready) begin
               cw.psel = PSEL_INC;
               if (dec_class == CL_LDUR) begin
                  cw.regw = 1'b1;
               end else begin
                  cw.ramw = 1'b1;
               end
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            cw = CW_ZERO;
         end
      endcase
   end

   assign controlword = cw;
   assign state       = state_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a behavioural model.
module tb_instr_sequencer;
   import legv8_ctrl_pkg::FS_ADD;
   import legv8_ctrl_pkg::FS_SUB;
   import legv8_ctrl_pkg::FS_PASSB;

   localparam logic [30:0] FETCH_CW = 31'h1FFFC048;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem_data = '0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic [30:0] controlword;
   logic [63:0] K;
   logic [1:0]  state;
   logic        halted;

   int          vectors = 0;
   int          miscompares = 0;

   // Model state: 0 fetch, 1 exec, 2 mem, 3 halt.
   int          m_ph = 0;
   logic [31:0] m_ir = '0;
   logic [97:0] exp_v, act_v;   // {state, halted, K, controlword}
   int          strobes = 0;

   instr_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .alu_zero    (alu_zero),
      .controlword (controlword),
      .K           (K),
      .state       (state),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // 0 illegal, 1 ADD, 2 SUB, 3 ADDI, 4 LDUR, 5 STUR, 6 B, 7 CBZ
   function automatic int classify(logic [31:0] ir);
      if (ir[31:26] == 6'b000101)      return 6;
      if (ir[31:24] == 8'b10110100)    return 7;
      if (ir[31:22] == 10'b1001000100) return 3;
      if (ir[31:21] == 11'b10001011000) return 1;
      if (ir[31:21] == 11'b11001011000) return 2;
      if (ir[31:21] == 11'b11111000010) return 4;
      if (ir[31:21] == 11'b11111000000) return 5;
      return 0;
   endfunction

   function automatic longint spec_k(logic [31:0] ir, int cls);
      longint v;
      v = 0;
      case (cls)
         3: v = longint'(ir[21:10]);
         4, 5: begin
            v = longint'(ir[20:12]);
            if (v >= 64'sd256) v = v - 64'sd512;
         end
         6: begin
            v = longint'(ir[25:0]);
            if (v >= 64'sd33554432) v = v - 64'sd67108864;
         end
         7: begin
            v = longint'(ir[23:5]);
            if (v >= 64'sd262144) v = v - 64'sd524288;
         end
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [97:0] spec_view(int ph, logic [31:0] ir, logic mr, logic az);
      int         cls;
      logic [1:0] psel, st;
      logic [4:0] da, sa, sb, fs;
      logic       regw, ramw, enm, ena, enpc, bsel, pcsel, sl, hlt;
      longint     kv;
      cls  = classify(ir);
      psel = 2'b00; da = 5'd31; sa = 5'd31; sb = 5'd31; fs = 5'd0;
      regw = 0; ramw = 0; enm = 0; ena = 0; enpc = 0; bsel = 0; pcsel = 0; sl = 0;
      kv   = 0;
      st   = 2'(ph);
      hlt  = (ph == 3);
      if (ph == 0) begin
         enm = 1; enpc = 1;
      end else if (ph == 3 || cls == 0) begin
         da = 5'd0; sa = 5'd0; sb = 5'd0;
      end else begin
         kv = spec_k(ir, cls);
         case (cls)
            1, 2, 3: begin
               sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0];
               fs = (cls == 2) ? FS_SUB : FS_ADD;
               ena = 1; regw = 1; sl = ir[29]; psel = 2'b01; bsel = (cls == 3);
            end
            4, 5: begin
               sa = ir[9:5]; bsel = 1; fs = FS_ADD; ena = 1;
               if (ph == 2) begin
                  enm = 1;
                  if (cls == 4) da = ir[4:0]; else sb = ir[4:0];
                  if (mr) begin
                     psel = 2'b01;
                     if (cls == 4) regw = 1; else ramw = 1;
                  end
               end
            end
            6: begin psel = 2'b11; pcsel = 1; end
            7: begin
               sb = ir[4:0]; fs = FS_PASSB; ena = 1;
               if (az) begin psel = 2'b11; pcsel = 1; end
               else psel = 2'b01;
            end
            default: ;
         endcase
      end
      return {st, hlt, kv, psel, da, sa, sb, fs, regw, ramw, enm, ena, 1'b0,
              enpc, bsel, pcsel, sl};
   endfunction

   // Drive inputs for one cycle and capture model/DUT views mid-cycle.
   task automatic apply_cycle(input logic [31:0] md, input logic mr, input logic az);
      mem_data = md; mem_ready = mr; alu_zero = az;
      @(negedge clock);
      exp_v = spec_view(m_ph, m_ir, mr, az);
      act_v = {state, halted, K, controlword};
      if (controlword[8] || controlword[7] || controlword[30:29] != 2'b00) strobes++;
   endtask

   // Step the model across the coming clock edge.
   task automatic advance_cycle();
      int cls;
      cls = classify(m_ir);
      case (m_ph)
         0: if (mem_ready) begin m_ir = mem_data; m_ph = 1; end
         1: m_ph = (cls == 0) ? 3 : ((cls == 4 || cls == 5) ? 2 : 0);
         2: if (mem_ready) m_ph = 0;
         default: ;
      endcase
      @(posedge clock); #1;
   endtask

   function automatic logic [31:0] rand_instr(int cls);
      logic [31:0] r;
      r = $urandom();
      case (cls)
         1: return {11'b10001011000, r[20:0]};
         2: return {11'b11001011000, r[20:0]};
         3: return {10'b1001000100, r[21:0]};
         4: return {11'b11111000010, r[20:0]};
         5: return {11'b11111000000, r[20:0]};
         6: return {6'b000101, r[25:0]};
         default: return {8'b10110100, r[23:0]};
      endcase
   endfunction

   task automatic test_reset();
      apply_cycle(32'hDEADBEEF, 1'b1, 1'b0);
      if (act_v !== exp_v) begin
         miscompares++; $display("FAIL reset_view: got %h want %h", act_v, exp_v);
      end
      vectors++;
      if (controlword !== FETCH_CW || K !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_word: got cw=%h K=%h want cw=%h K=0", controlword, K, FETCH_CW);
      end
      vectors++;
      mem_ready = 1'b0;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_add();
      apply_cycle(32'h8B030041, 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b0);
      if (act_v !== exp_v) begin
         miscompares++; $display("FAIL add_exec: got %h want %h", act_v, exp_v);
      end
      vectors++;
      if ({state, controlword[30:14], controlword[8]} !== {2'b01, 2'b01, 5'd1, 5'd2, 5'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL add_fields: got state=%0d cw=%h want state=1 DA=1 SA=2 SB=3 regW=1 Psel=01",
                  state, controlword);
      end
      vectors++;
      advance_cycle();
      apply_cycle($urandom(), 1'b0, 1'b0);
      if (state !== 2'b00 || act_v !== exp_v) begin
         miscompares++; $display("FAIL add_return: got %h want %h", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
   endtask

   task automatic test_ldur_wait();
      apply_cycle(32'hF84080C5, 1'b0, 1'b0);
      advance_cycle();
      apply_cycle(32'hF84080C5, 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b0);
      if (act_v !== exp_v || K !== 64'd8 || controlword[2] !== 1'b1) begin
         miscompares++; $display("FAIL ldur_exec: got %h want %h (K=8 Bsel=1)", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
      for (int i = 0; i < 3; i++) begin
         apply_cycle($urandom(), 1'b0, 1'b0);
         if (act_v !== exp_v || controlword[8] !== 1'b0 || state !== 2'b10) begin
            miscompares++; $display("FAIL ldur_wait%0d: got %h want %h", i, act_v, exp_v);
         end
         vectors++;
         advance_cycle();
      end
      apply_cycle($urandom(), 1'b1, 1'b0);
      if (act_v !== exp_v || controlword[8] !== 1'b1 || controlword[28:24] !== 5'd5 ||
          controlword[30:29] !== 2'b01) begin
         miscompares++; $display("FAIL ldur_done: got %h want %h", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
   endtask

   task automatic test_branch();
      apply_cycle(32'h17FFFFFF, 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b1);
      if (act_v !== exp_v || K !== 64'hFFFFFFFFFFFFFFFF || controlword[30:29] !== 2'b11 ||
          controlword[1] !== 1'b1) begin
         miscompares++; $display("FAIL b_exec: got %h want %h", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
      apply_cycle($urandom(), 1'b0, 1'b0);
      if (state !== 2'b00) begin
         miscompares++; $display("FAIL b_cycles: got state=%0d want 0", state);
      end
      vectors++;
      advance_cycle();
   endtask

   task automatic test_cbz();
      for (int z = 1; z >= 0; z--) begin
         apply_cycle(32'hB4000087, 1'b1, 1'b0);
         advance_cycle();
         apply_cycle($urandom(), 1'b0, z[0]);
         if (act_v !== exp_v || K !== 64'd4 || controlword[30:29] !== (z[0] ? 2'b11 : 2'b01)) begin
            miscompares++; $display("FAIL cbz_z%0d: got %h want %h", z, act_v, exp_v);
         end
         vectors++;
         advance_cycle();
      end
   endtask

   task automatic test_random();
      logic [31:0] instr;
      logic        mr, az;
      int          cls;
      bit          started, done;
      for (int n = 0; n < 80; n++) begin
         cls = int'($urandom_range(1, 7));
         instr = rand_instr(cls);
         strobes = 0; started = 0; done = 0;
         for (int c = 0; c < 40 && !done; c++) begin
            mr = ($urandom_range(0, 2) != 0);
            az = $urandom_range(0, 1) != 0;
            apply_cycle((m_ph == 0) ? instr : $urandom(), mr, az);
            if (act_v !== exp_v) begin
               miscompares++;
               $display("FAIL rand_%0d_ir%h: got %h want %h", n, instr, act_v, exp_v);
            end
            vectors++;
            if (m_ph != 0) started = 1;
            advance_cycle();
            if (started && m_ph == 0) done = 1;
         end
         if (!done) begin
            miscompares++; $display("FAIL rand_%0d_timeout: got no completion want completion", n);
         end
         vectors++;
         if (strobes !== 1) begin
            miscompares++; $display("FAIL rand_%0d_strobes: got %0d want 1", n, strobes);
         end
         vectors++;
      end
   endtask

   task automatic test_reset_mid_stur();
      apply_cycle(32'hF80000C5, 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b0);
      if (act_v !== exp_v || controlword[7] !== 1'b1) begin
         miscompares++; $display("FAIL stur_mem: got %h want %h", act_v, exp_v);
      end
      vectors++;
      #2;
      reset_n = 1'b0;
      #1;
      if (controlword !== FETCH_CW || state !== 2'b00 || controlword[7] !== 1'b0 || K !== 64'd0) begin
         miscompares++;
         $display("FAIL stur_reset: got state=%0d cw=%h K=%h want state=0 cw=%h K=0",
                  state, controlword, K, FETCH_CW);
      end
      vectors++;
      m_ph = 0; m_ir = '0;
      mem_ready = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_illegal_halt();
      apply_cycle(32'h00000000, 1'b1, 1'b0);
      advance_cycle();
      apply_cycle($urandom(), 1'b1, 1'b1);
      if (act_v !== exp_v || controlword !== 31'd0 || state !== 2'b01) begin
         miscompares++; $display("FAIL illegal_exec: got %h want %h", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
      for (int i = 0; i < 6; i++) begin
         apply_cycle($urandom(), i[0], i[1]);
         if (act_v !== exp_v || state !== 2'b11 || halted !== 1'b1) begin
            miscompares++; $display("FAIL halt_sticky%0d: got %h want %h", i, act_v, exp_v);
         end
         vectors++;
         advance_cycle();
      end
      reset_n = 1'b0;
      #1;
      if (state !== 2'b00 || halted !== 1'b0 || controlword !== FETCH_CW) begin
         miscompares++;
         $display("FAIL halt_reset: got state=%0d halted=%0b cw=%h want state=0 halted=0 cw=%h",
                  state, halted, controlword, FETCH_CW);
      end
      vectors++;
      m_ph = 0; m_ir = '0;
      mem_ready = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      apply_cycle(32'h8B030041, 1'b0, 1'b0);
      if (act_v !== exp_v) begin
         miscompares++; $display("FAIL post_reset: got %h want %h", act_v, exp_v);
      end
      vectors++;
      advance_cycle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_ldur_wait();
      test_branch();
      test_cbz();
      test_random();
      test_reset_mid_stur();
      test_illegal_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
